// File: rtl/fifo_rptr_rempty.sv
// fifo_rptr_rempty: read-side pointer and empty/occupancy logic of an async FIFO.
// Synchronises the Gray write pointer into Rclk, keeps the binary/Gray read
// pointer, and produces empty, almost-empty, occupancy and a sticky underflow.
// Ports:
//   Rclk          - read-domain clock
//   Rrst          - synchronous active-low reset
//   Rinc          - read request (ignored while Rempty=1)
//   Rclr_err      - clears the sticky underflow flag
//   Rwptr         - Gray write pointer from the write domain (asynchronous)
//   Radder        - memory read address
//   Rptr          - Gray read pointer for the write domain
//   Rempty        - FIFO empty
//   Ralmost_empty - occupancy <= AE_LEVEL
//   Rcount        - occupancy as seen by the read side
//   Runderflow    - sticky: read attempted while empty
module fifo_rptr_rempty #(
    parameter int Address  = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic               Rclk,
    input  logic               Rrst,
    input  logic               Rinc,
    input  logic               Rclr_err,
    input  logic [Address:0]   Rwptr,
    output logic [Address-1:0] Radder,
    output logic [Address:0]   Rptr,
    output logic               Rempty,
    output logic               Ralmost_empty,
    output logic [Address:0]   Rcount,
    output logic               Runderflow
);

    localparam int unsigned PW     = Address + 1;
    localparam int unsigned AE_LVL = $unsigned(AE_LEVEL);

    logic [PW-1:0] rq1_wptr_q, rq2_wptr_q;
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic [PW-1:0] rcount_q, rcount_d;
    logic [PW-1:0] wbin_s;
    logic          rempty_q, rempty_d;
    logic          rae_q, rae_d;
    logic          runder_q, runder_d;
    logic          rinc_ok;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-state: pointer advance, flags and occupancy from the synchronised write pointer.
    always_comb begin
        rinc_ok  = Rinc & ~rempty_q;
        rbin_d   = rbin_q + PW'(rinc_ok);
        rgray_d  = (rbin_d >> 1) ^ rbin_d;
        wbin_s   = gray2bin(rq2_wptr_q);
        rcount_d = wbin_s - rbin_d;
        rempty_d = (rgray_d == rq2_wptr_q);
        rae_d    = (32'(rcount_d) <= AE_LVL);
        // Set dominates clear when both happen on the same edge.
        runder_d = (Rinc & rempty_q) | (runder_q & ~Rclr_err);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Rclk) begin
        if (!Rrst) begin
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            rbin_q     <= '0;
            rptr_q     <= '0;
            rcount_q   <= '0;
            rempty_q   <= 1'b1;
            rae_q      <= 1'b1;
            runder_q   <= 1'b0;
        end else begin
            rq1_wptr_q <= Rwptr;
            rq2_wptr_q <= rq1_wptr_q;
            rbin_q     <= rbin_d;
            rptr_q     <= rgray_d;
            rcount_q   <= rcount_d;
            rempty_q   <= rempty_d;
            rae_q      <= rae_d;
            runder_q   <= runder_d;
        end
    end

    assign Radder        = rbin_q[Address-1:0];
    assign Rptr          = rptr_q;
    assign Rempty        = rempty_q;
    assign Ralmost_empty = rae_q;
    assign Rcount        = rcount_q;
    assign Runderflow    = runder_q;

endmodule

// File: tb/tb_fifo_rptr_rempty.sv
// Directed bench for fifo_rptr_rempty with Address=3, AE_LEVEL=1.
module tb_fifo_rptr_rempty;

    logic       clk = 1'b0;
    logic       rrst, rinc, rclr;
    logic [3:0] rwptr;
    logic [2:0] radder;
    logic [3:0] rptr;
    logic       rempty, rae;
    logic [3:0] rcount;
    logic       runder;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] drain_ptr [4] = '{4'd1, 4'd3, 4'd2, 4'd6};

    fifo_rptr_rempty #(.Address(3), .AE_LEVEL(1)) dut (
        .Rclk(clk), .Rrst(rrst), .Rinc(rinc), .Rclr_err(rclr), .Rwptr(rwptr),
        .Radder(radder), .Rptr(rptr), .Rempty(rempty), .Ralmost_empty(rae),
        .Rcount(rcount), .Runderflow(runder)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a new write pointer and let it cross the two-flop synchroniser.
    task automatic wsync(input logic [3:0] g);
        rwptr = g;
        rinc  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rd(input int n);
        rinc = 1'b1;
        repeat (n) tick();
        rinc = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rptr"},   32'(rptr),   32'd0);
        chk({tag, "_radder"}, 32'(radder), 32'd0);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_rae"},    32'(rae),    32'd1);
        chk({tag, "_rcount"}, 32'(rcount), 32'd0);
        chk({tag, "_runder"}, 32'(runder), 32'd0);
    endtask

    initial begin
        rrst = 1'b0; rinc = 1'b0; rclr = 1'b0; rwptr = 4'd0;
        tick(); tick();
        chk_reset("reset");
        rrst = 1'b1;

        // Fill: write pointer to binary 4 (Gray 6); empty drops on the 3rd edge.
        rwptr = 4'd6;
        tick(); tick();
        chk("fill_empty_edge2", 32'(rempty), 32'd1);
        chk("fill_count_edge2", 32'(rcount), 32'd0);
        tick();
        chk("fill_empty_edge3", 32'(rempty), 32'd0);
        chk("fill_count_edge3", 32'(rcount), 32'd4);
        chk("fill_ae_edge3",    32'(rae),    32'd0);

        // Drain four entries.
        for (int i = 0; i < 4; i++) begin
            chk("drain_radder", 32'(radder), 32'(i));
            rinc = 1'b1;
            tick();
            chk("drain_rptr",   32'(rptr),   32'(drain_ptr[i]));
            chk("drain_rcount", 32'(rcount), 32'(3 - i));
            chk("drain_ae",     32'(rae),    (i >= 2) ? 32'd1 : 32'd0);
            chk("drain_empty",  32'(rempty), (i == 3) ? 32'd1 : 32'd0);
        end

        // Underflow: read while empty leaves the pointer alone and sets the sticky flag.
        tick();
        chk("uf_rptr_hold", 32'(rptr),   32'd6);
        chk("uf_radder",    32'(radder), 32'd4);
        chk("uf_set",       32'(runder), 32'd1);
        rinc = 1'b0;
        tick();
        chk("uf_sticky", 32'(runder), 32'd1);
        rinc = 1'b1; rclr = 1'b1;
        tick();
        chk("uf_set_wins", 32'(runder), 32'd1);
        rinc = 1'b0;
        tick();
        chk("uf_cleared", 32'(runder), 32'd0);
        rclr = 1'b0;

        // Walk the read pointer to binary 14: write 8 (G12), read 4; write 12 (G10), read 4;
        // write 14 (G9), read 2.
        wsync(4'd12); rd(4);
        chk("walk_radder8", 32'(radder), 32'd0);
        wsync(4'd10); rd(4);
        chk("walk_radder12", 32'(radder), 32'd4);
        wsync(4'd9); rd(2);
        chk("walk_rptr14",  32'(rptr),   32'd9);
        chk("walk_radder14", 32'(radder), 32'd6);
        chk("walk_empty",   32'(rempty), 32'd1);

        // Wrap: write side at 17 mod 16 = 1 (Gray 1); 3 entries across the rollover.
        wsync(4'd1);
        chk("wrap_count", 32'(rcount), 32'd3);
        chk("wrap_empty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        tick();
        chk("wrap1_radder", 32'(radder), 32'd7);
        chk("wrap1_rptr",   32'(rptr),   32'd8);
        chk("wrap1_count",  32'(rcount), 32'd2);
        tick();
        chk("wrap2_radder", 32'(radder), 32'd0);
        chk("wrap2_rptr",   32'(rptr),   32'd0);
        chk("wrap2_ae",     32'(rae),    32'd1);
        tick();
        chk("wrap3_rptr",  32'(rptr),   32'd1);
        chk("wrap3_count", 32'(rcount), 32'd0);
        chk("wrap3_empty", 32'(rempty), 32'd1);
        rinc = 1'b0;

        // Net-out: write arrival (4 -> 5) lands on the same edge as a read.
        wsync(4'd6);
        chk("net_pre_count", 32'(rcount), 32'd3);
        rwptr = 4'd7;
        tick(); tick();
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("net_count",  32'(rcount), 32'd3);
        chk("net_empty",  32'(rempty), 32'd0);
        chk("net_radder", 32'(radder), 32'd2);

        // Mid-reset: rebuild occupancy 3 from a clean pointer, then reset while reading.
        rrst = 1'b0;
        tick();
        rrst = 1'b1;
        wsync(4'd2);
        chk("mr_pre_count", 32'(rcount), 32'd3);
        rinc = 1'b1; rrst = 1'b0;
        tick();
        chk_reset("midreset");
        tick();
        chk("midreset_hold_rptr", 32'(rptr), 32'd0);
        rinc = 1'b0; rrst = 1'b1;
        tick(); tick();
        chk("mr_resync_edge2", 32'(rcount), 32'd0);
        tick();
        chk("mr_resync_count", 32'(rcount), 32'd3);
        chk("mr_resync_empty", 32'(rempty), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
